mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 30 +++
 rtl/mem_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder_pkg.sv
// ============================================================================
// Module : mem_responder_pkg
// Brief  : Shared bus constants plus FSM state and request-kind encodings.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_responder_pkg;

    localparam int c_BUS_ADDR_W = 32;
    localparam int c_BUS_DATA_W = 32;
    localparam int c_BUS_STRB_W = 4;
    localparam int c_WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        KIND_INST  = 2'd0,
        KIND_DREAD = 2'd1,
        KIND_WRITE = 2'd2
    } kind_t;

endpackage

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module : mem_responder
// Brief  : Arbitrates instruction/data cache requests onto one RAM port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [c_BUS_ADDR_W-1:0] inst_cache_addr,
    input  logic                    inst_cache_ren,
    output logic                    inst_cache_ok,
    output logic [c_BUS_DATA_W-1:0] inst_cache_rdata,
    input  logic [c_BUS_ADDR_W-1:0] data_cache_addr,
    input  logic                    data_cache_ren,
    input  logic [c_BUS_STRB_W-1:0] data_cache_wen,
    input  logic [c_BUS_DATA_W-1:0] data_cache_wdata,
    output logic                    data_cache_read_ok,
    output logic                    data_cache_write_ok,
    output logic [c_BUS_DATA_W-1:0] data_cache_rdata,
    output logic                    ram_en,
    output logic [c_BUS_STRB_W-1:0] ram_wen,
    output logic [DEPTH_LOG2-1:0]   ram_addr,
    output logic [c_BUS_DATA_W-1:0] ram_wdata,
    input  logic [c_BUS_DATA_W-1:0] ram_rdata,
    output logic                    req_overrun
);

    localparam logic [c_WAIT_CNT_W-1:0] c_WAIT_LAST =
        (WAIT_CYCLES > 0) ? c_WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t                    r_state;
    state_t                    w_state_nxt;
    kind_t                     r_kind;
    kind_t                     w_sel_kind;
    logic                      w_sel_valid;
    logic [DEPTH_LOG2-1:0]     w_sel_addr;
    logic                      w_take_i;
    logic                      w_take_d;
    logic [DEPTH_LOG2-1:0]     r_addr;
    logic [c_BUS_STRB_W-1:0]   r_wen;
    logic [c_BUS_DATA_W-1:0]   r_wdata;
    logic [c_WAIT_CNT_W-1:0]   r_wait_cnt;
    logic                      r_pend_i;
    logic                      r_pend_d;
    logic [DEPTH_LOG2-1:0]     r_pend_i_addr;
    logic [DEPTH_LOG2-1:0]     r_pend_d_addr;
    logic                      r_just_wrote;
    logic                      r_overrun;
    logic [c_BUS_DATA_W-1:0]   r_inst_rdata;
    logic [c_BUS_DATA_W-1:0]   r_data_rdata;
    logic                      w_unused_addr_bits;

    assign w_unused_addr_bits = ^{inst_cache_addr[c_BUS_ADDR_W-1:DEPTH_LOG2+2], inst_cache_addr[1:0],
                                  data_cache_addr[c_BUS_ADDR_W-1:DEPTH_LOG2+2], data_cache_addr[1:0]};

    // Priority: write, data read, instruction read. A pending flag wins over a
    // live pulse of the same kind so a merged pulse keeps the first address.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_kind  = KIND_INST;
        w_sel_addr  = inst_cache_addr[DEPTH_LOG2+1:2];
        if ((data_cache_wen != '0) && !r_just_wrote) begin
            w_sel_valid = 1'b1;
            w_sel_kind  = KIND_WRITE;
            w_sel_addr  = data_cache_addr[DEPTH_LOG2+1:2];
        end else if (r_pend_d) begin
            w_sel_valid = 1'b1;
            w_sel_kind  = KIND_DREAD;
            w_sel_addr  = r_pend_d_addr;
        end else if (data_cache_ren) begin
            w_sel_valid = 1'b1;
            w_sel_kind  = KIND_DREAD;
            w_sel_addr  = data_cache_addr[DEPTH_LOG2+1:2];
        end else if (r_pend_i) begin
            w_sel_valid = 1'b1;
            w_sel_kind  = KIND_INST;
            w_sel_addr  = r_pend_i_addr;
        end else if (inst_cache_ren) begin
            w_sel_valid = 1'b1;
            w_sel_kind  = KIND_INST;
            w_sel_addr  = inst_cache_addr[DEPTH_LOG2+1:2];
        end
    end

    assign w_take_i = (r_state == ST_IDLE) && w_sel_valid && (w_sel_kind == KIND_INST);
    assign w_take_d = (r_state == ST_IDLE) && w_sel_valid && (w_sel_kind == KIND_DREAD);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    w_state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_kind        <= KIND_INST;
            r_addr        <= '0;
            r_wen         <= '0;
            r_wdata       <= '0;
            r_wait_cnt    <= '0;
            r_pend_i      <= 1'b0;
            r_pend_d      <= 1'b0;
            r_pend_i_addr <= '0;
            r_pend_d_addr <= '0;
            r_just_wrote  <= 1'b0;
            r_overrun     <= 1'b0;
            r_inst_rdata  <= '0;
            r_data_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;

            if ((r_state == ST_IDLE) && w_sel_valid) begin
                r_kind <= w_sel_kind;
                r_addr <= w_sel_addr;
                if (w_sel_kind == KIND_WRITE) begin
                    r_wen   <= data_cache_wen;
                    r_wdata <= data_cache_wdata;
                end else begin
                    r_wen <= '0;
                end
            end

            r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + 1'b1 : '0;

            if (w_take_i) begin
                r_pend_i <= 1'b0;
            end else if (inst_cache_ren) begin
                if (r_pend_i) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pend_i_addr <= inst_cache_addr[DEPTH_LOG2+1:2];
                end
                r_pend_i <= 1'b1;
            end

            if (w_take_d) begin
                r_pend_d <= 1'b0;
            end else if (data_cache_ren) begin
                if (r_pend_d) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pend_d_addr <= data_cache_addr[DEPTH_LOG2+1:2];
                end
                r_pend_d <= 1'b1;
            end

            // Keeps a still-visible wen from being served twice right after write_ok.
            r_just_wrote <= (r_state == ST_RESP) && (r_kind == KIND_WRITE);

            if (inst_cache_ok) begin
                r_inst_rdata <= ram_rdata;
            end
            if (data_cache_read_ok) begin
                r_data_rdata <= ram_rdata;
            end
        end
    end

    assign inst_cache_ok       = (r_state == ST_RESP) && (r_kind == KIND_INST);
    assign data_cache_read_ok  = (r_state == ST_RESP) && (r_kind == KIND_DREAD);
    assign data_cache_write_ok = (r_state == ST_RESP) && (r_kind == KIND_WRITE);

    // RAM data arrives only in the ok cycle, so it is forwarded then and held afterwards.
    assign inst_cache_rdata = inst_cache_ok      ? ram_rdata : r_inst_rdata;
    assign data_cache_rdata = data_cache_read_ok ? ram_rdata : r_data_rdata;

    assign ram_en      = (r_state == ST_ACCESS);
    assign ram_wen     = (ram_en && (r_kind == KIND_WRITE)) ? r_wen : '0;
    assign ram_addr    = r_addr;
    assign ram_wdata   = r_wdata;
    assign req_overrun = r_overrun;

endmodule

`default_nettype wire
